dist_ram_mp: RTL and testbench

//   Multi-read-port distributed (LUT) RAM: one byte-enabled write port, NUM_RD read ports.

---
 rtl/dist_ram_mp.sv | 104 ++++++++++
 tb/tb_dist_ram_mp.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dist_ram_mp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dist_ram_mp : multi-read-port LUT RAM with byte-enabled write port and   |
// | clear sequencer. Macro DIST_RAM_MP_RDREG_EN adds registered read ports.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module dist_ram_mp #(
   parameter int                WIDTH      = 16,
   parameter int                BYTE_W     = 8,
   parameter int                DEPTH      = 64,
   parameter int                NUM_RD     = 2,
   parameter int                CLR_ON_RST = 1,
   parameter logic [WIDTH-1:0]  INIT_VAL   = '0,
   parameter string             INIT_FILE  = "",
   localparam int               NBE        = WIDTH / BYTE_W,
   localparam int               AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr_i,
   output logic                     busy_o,
   input  logic                     wr_en_i,
   input  logic [AW-1:0]            wr_addr_i,
   input  logic [NBE-1:0]           wr_be_i,
   input  logic [WIDTH-1:0]         wr_data_i,
   input  logic [NUM_RD*AW-1:0]     rd_addr_i,
   output logic [NUM_RD*WIDTH-1:0]  rd_data_o
);

   localparam logic [AW:0]   C_DEPTH    = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] C_LAST_ADR = AW'(DEPTH - 1);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_CLEAR = 1'b1
   } state_e;

   state_e            state_q;
   logic [AW-1:0]     cnt_q;
   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic              wr_ok;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= (CLR_ON_RST != 0) ? S_CLEAR : S_IDLE;
         cnt_q   <= '0;
      end else if (clr_i) begin
         state_q <= S_CLEAR;
         cnt_q   <= '0;
      end else if (state_q == S_CLEAR) begin
         if (cnt_q == C_LAST_ADR) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
         end else begin
            cnt_q   <= cnt_q + 1'b1;
         end
      end
   end

   assign busy_o = (state_q == S_CLEAR);
   assign wr_ok  = wr_en_i && !busy_o && ({1'b0, wr_addr_i} < C_DEPTH);

   // The array has no reset; only the sweep or the write port ever changes it.
   always_ff @(posedge clk) begin
      if (busy_o) begin
         mem_q[cnt_q] <= INIT_VAL;
      end else if (wr_ok) begin
         for (int i = 0; i < NBE; i++) begin
            if (wr_be_i[i]) begin
               mem_q[wr_addr_i][i*BYTE_W +: BYTE_W] <= wr_data_i[i*BYTE_W +: BYTE_W];
            end
         end
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [AW-1:0]    rd_a;
      logic [WIDTH-1:0] rd_comb;

      assign rd_a    = rd_addr_i[k*AW +: AW];
      assign rd_comb = (busy_o || ({1'b0, rd_a} >= C_DEPTH)) ? '0 : mem_q[rd_a];

`ifdef DIST_RAM_MP_RDREG_EN
      logic [WIDTH-1:0] rd_q;

      // A clr edge zeroes the register too, so no stale word appears while busy.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rd_q <= '0;
         end else if (clr_i || busy_o) begin
            rd_q <= '0;
         end else begin
            rd_q <= rd_comb;
         end
      end

      assign rd_data_o[k*WIDTH +: WIDTH] = rd_q;
`else
      assign rd_data_o[k*WIDTH +: WIDTH] = rd_comb;
`endif
   end

endmodule
`default_nettype wire

// File: tb/tb_dist_ram_mp.sv
`default_nettype none
// Randomised and directed bench for dist_ram_mp against an array-based reference model.
module tb_dist_ram_mp;

   localparam int WIDTH  = 16;
   localparam int BYTE_W = 8;
   localparam int DEPTH  = 48;
   localparam int NUM_RD = 2;
   localparam int NBE    = WIDTH / BYTE_W;
   localparam int AW     = 6;
`ifdef DIST_RAM_MP_RDREG_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 0;
`endif

   logic                     clk;
   logic                     rst_n;
   logic                     clr;
   logic                     busy;
   logic                     wr_en;
   logic [AW-1:0]            wr_addr;
   logic [NBE-1:0]           wr_be;
   logic [WIDTH-1:0]         wr_data;
   logic [NUM_RD*AW-1:0]     rd_addr;
   logic [NUM_RD*WIDTH-1:0]  rd_data;

   dist_ram_mp #(
      .WIDTH(WIDTH), .BYTE_W(BYTE_W), .DEPTH(DEPTH), .NUM_RD(NUM_RD),
      .CLR_ON_RST(1), .INIT_VAL(16'h0000), .INIT_FILE("")
   ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (clr),
      .busy_o    (busy),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_addr),
      .wr_be_i   (wr_be),
      .wr_data_i (wr_data),
      .rd_addr_i (rd_addr),
      .rd_data_o (rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: word array plus the number of sweep cycles still to run.
   logic [WIDTH-1:0] mdl_mem [DEPTH];
   logic [WIDTH-1:0] exp_reg [NUM_RD];
   int               left;
   logic             obs_busy;
   logic [WIDTH-1:0] obs_rd [NUM_RD];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [WIDTH-1:0] ref_rd(input int a);
      if (left > 0 || a >= DEPTH) return '0;
      return mdl_mem[a];
   endfunction

   // One clock: compare at negedge, advance the model, return 1 ns after posedge.
   task automatic step();
      logic [WIDTH-1:0] nxt [NUM_RD];
      logic [WIDTH-1:0] expv;
      int ra;
      @(negedge clk);
      if (!rst_n) left = DEPTH;
      obs_busy = busy;
      check_eq("busy", {31'b0, busy}, {31'b0, (left > 0)});
      for (int k = 0; k < NUM_RD; k++) begin
         ra = int'(rd_addr[k*AW +: AW]);
         obs_rd[k] = rd_data[k*WIDTH +: WIDTH];
         if (LAT == 0) expv = ref_rd(ra);
         else          expv = rst_n ? exp_reg[k] : '0;
         check_eq("rd_data", {16'b0, obs_rd[k]}, {16'b0, expv});
         nxt[k] = (!rst_n || clr || left > 0) ? '0 : ref_rd(ra);
      end
      if (rst_n) begin
         if (left == 0 && wr_en && int'(wr_addr) < DEPTH) begin
            for (int i = 0; i < NBE; i++)
               if (wr_be[i]) mdl_mem[wr_addr][i*BYTE_W +: BYTE_W] = wr_data[i*BYTE_W +: BYTE_W];
         end
         if (left > 0) begin
            mdl_mem[DEPTH-left] = '0;
            left--;
         end
         if (clr) left = DEPTH;
      end
      for (int k = 0; k < NUM_RD; k++) exp_reg[k] = nxt[k];
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      clr   = 1'b0;
      wr_en = 1'b0;
      wr_be = '0;
   endtask

   task automatic do_write(input int a, input logic [NBE-1:0] be, input logic [WIDTH-1:0] d);
      wr_en   = 1'b1;
      wr_addr = AW'(a);
      wr_be   = be;
      wr_data = d;
      step();
      wr_en   = 1'b0;
   endtask

   task automatic set_rd(input int a0, input int a1);
      rd_addr = {AW'(a1), AW'(a0)};
   endtask

   // Steps until busy drops; returns the number of cycles busy was observed high.
   task automatic count_busy(output int n);
      int guard;
      n = 0;
      guard = 0;
      do begin
         step();
         if (obs_busy) n++;
         guard++;
      end while (obs_busy && guard < 300);
      if (guard >= 300) check_eq("busy_timeout", 32'(guard), 32'(0));
   endtask

   int n;
   logic [WIDTH-1:0] hist [3];

   initial begin
      for (int a = 0; a < DEPTH; a++) mdl_mem[a] = '0;
      for (int k = 0; k < NUM_RD; k++) exp_reg[k] = '0;
      left    = 0;
      rst_n   = 1'b1;
      wr_addr = '0;
      wr_data = '0;
      rd_addr = '0;
      idle_inputs();
      #1 rst_n = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;

      // Sweep after reset release lasts exactly DEPTH cycles, then array reads zero.
      count_busy(n);
      check_eq("rst_sweep_len", 32'(n), 32'(DEPTH));
      for (int a = 0; a < DEPTH; a++) begin
         set_rd(a, DEPTH - 1 - a);
         step();
      end

      // Byte lanes.
      do_write(5, 2'b11, 16'hABCD);
      do_write(5, 2'b01, 16'h0012);
      set_rd(5, 5);
      step(); step();
      check_eq("be_lane0", {16'b0, obs_rd[0]}, 32'h0000AB12);
      do_write(5, 2'b00, 16'hFFFF);
      step(); step();
      check_eq("be_none", {16'b0, obs_rd[1]}, 32'h0000AB12);

      // Two independent ports in the same cycle.
      do_write(5, 2'b11, 16'h1111);
      do_write(9, 2'b11, 16'h2222);
      set_rd(5, 9);
      step(); step();
      check_eq("port0", {16'b0, obs_rd[0]}, 32'h00001111);
      check_eq("port1", {16'b0, obs_rd[1]}, 32'h00002222);

      // Read-during-write returns the old word.
      do_write(7, 2'b11, 16'h1234);
      set_rd(7, 9);
      step();
      wr_en = 1'b1; wr_addr = 6'd7; wr_be = 2'b11; wr_data = 16'h5555;
      for (int i = 0; i < 3; i++) begin
         step();
         wr_en = 1'b0;
         hist[i] = obs_rd[0];
      end
      check_eq("rdw_old", {16'b0, hist[LAT]}, 32'h00001234);
      check_eq("rdw_new", {16'b0, hist[LAT+1]}, 32'h00005555);

      // Out-of-range write dropped and out-of-range read returns zero.
      do_write(50, 2'b11, 16'h7777);
      set_rd(50, 2);
      step(); step();
      check_eq("oor_rd", {16'b0, obs_rd[0]}, 32'h0);

      // Second clr 30 cycles into a sweep restarts it.
      set_rd(9, 5);
      clr = 1'b1;
      step();
      clr = 1'b0;
      n = 0;
      for (int c = 0; c < 29; c++) begin
         wr_en = 1'(c % 3 == 0); wr_addr = AW'(c); wr_be = 2'b11; wr_data = 16'hDEAD;
         step();
         if (obs_busy) n++;
      end
      check_eq("busy_rd0", {16'b0, obs_rd[0]}, 32'h0);
      wr_en = 1'b0;
      clr = 1'b1;
      step();
      if (obs_busy) n++;
      clr = 1'b0;
      begin
         int m;
         count_busy(m);
         n += m;
      end
      check_eq("reclr_len", 32'(n), 32'(30 + DEPTH));

      // Reset 20 cycles into a sweep aborts it; release starts a full sweep.
      do_write(3, 2'b11, 16'hBEEF);
      clr = 1'b1;
      step();
      clr = 1'b0;
      repeat (20) step();
      rst_n = 1'b0;
      set_rd(3, 9);
      step(); step();
      check_eq("rst_busy", {31'b0, obs_busy}, 32'h1);
      check_eq("rst_rd", {16'b0, obs_rd[0]}, 32'h0);
      rst_n = 1'b1;
      count_busy(n);
      check_eq("rst_resweep_len", 32'(n), 32'(DEPTH));

      // Random traffic against the model.
      for (int c = 0; c < 600; c++) begin
         clr     = ($urandom_range(0, 79) == 0);
         wr_en   = $urandom_range(0, 1) == 1;
         wr_addr = AW'($urandom_range(0, DEPTH + 7));
         wr_be   = NBE'($urandom);
         wr_data = WIDTH'($urandom);
         for (int k = 0; k < NUM_RD; k++)
            rd_addr[k*AW +: AW] = ($urandom_range(0, 1) == 1) ? wr_addr
                                                              : AW'($urandom_range(0, DEPTH + 7));
         step();
      end
      idle_inputs();
      repeat (2) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
